// File: rtl/fetch_pkg.sv
// Shared definitions for the instruction fetch slice: default widths,
// the queue entry layout and a small width helper.
package fetch_pkg;

    localparam int FETCH_ADDR_W  = 32;
    localparam int FETCH_INSTR_W = 32;

    // One prefetch queue entry: the instruction and the address it came from.
    typedef struct packed {
        logic [FETCH_ADDR_W-1:0]  pc;
        logic [FETCH_INSTR_W-1:0] instr;
    } fetch_entry_t;

    // Width of a packed {pc, instr} entry for arbitrary parameterisations.
    function automatic int entry_width(input int addr_w, input int instr_w);
        return addr_w + instr_w;
    endfunction

endpackage

// File: rtl/instr_fetch_unit_if.sv
// Bus bundle between the fetch unit, the instruction memory, decode and
// the branch unit. The master side is the fetch unit itself.
interface instr_fetch_unit_if
    import fetch_pkg::*;
#(
    parameter int ADDR_W  = FETCH_ADDR_W,
    parameter int INSTR_W = FETCH_INSTR_W
);

    logic               redirect_valid;
    logic [ADDR_W-1:0]  redirect_pc;
    logic               imem_req;
    logic [ADDR_W-1:0]  imem_addr;
    logic [INSTR_W-1:0] imem_rdata;
    logic               instr_valid;
    logic               instr_ready;
    logic [INSTR_W-1:0] instr;
    logic [ADDR_W-1:0]  instr_pc;

    modport master (
        input  redirect_valid,
        input  redirect_pc,
        output imem_req,
        output imem_addr,
        input  imem_rdata,
        output instr_valid,
        input  instr_ready,
        output instr,
        output instr_pc
    );

    modport slave (
        output redirect_valid,
        output redirect_pc,
        input  imem_req,
        input  imem_addr,
        output imem_rdata,
        input  instr_valid,
        output instr_ready,
        input  instr,
        input  instr_pc
    );

endinterface

// File: rtl/instr_fetch_unit_queue.sv
// Synchronous FIFO used as the prefetch queue. Flush wins over push and
// pop; a push into a full queue is accepted only when a pop frees a slot.
module fetch_queue #(
    parameter int QDEPTH = 4,
    parameter int WIDTH  = 64
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      push,
    input  logic [WIDTH-1:0]          push_data,
    input  logic                      pop,
    input  logic                      flush,
    output logic [WIDTH-1:0]          head_data,
    output logic                      full,
    output logic                      empty,
    output logic [$clog2(QDEPTH):0]   count
);

    localparam int PTR_W = $clog2(QDEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] storage [QDEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             push_ok;
    logic             pop_ok;

    // Qualify push/pop against occupancy so a full queue only takes data while draining.
    always_comb begin
        full    = (count == CNT_W'(QDEPTH));
        empty   = (count == '0);
        pop_ok  = pop && !empty;
        push_ok = push && (!full || pop_ok);
    end

    assign head_data = storage[rd_ptr];

    // Storage, pointers and occupancy; flush empties the queue regardless of push/pop.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < QDEPTH; i++) begin
                storage[i] <= '0;
            end
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) begin
                storage[wr_ptr] <= push_data;
                wr_ptr          <= wr_ptr + PTR_W'(1);
            end
            if (pop_ok) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({push_ok, pop_ok})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    // A push that finds the queue full with nothing leaving would lose data.
    assert property (@(posedge clk) disable iff (!rst_n)
                     !(push && full && !pop && !flush));

endmodule

// File: rtl/instr_fetch_unit.sv
// Fetch stage: owns the program counter, issues one-cycle-latency reads to
// instruction memory, buffers responses in a prefetch queue and supports
// branch redirects that flush queued and in-flight fetches.
module instr_fetch_unit
    import fetch_pkg::*;
#(
    parameter int                ADDR_W   = FETCH_ADDR_W,
    parameter int                INSTR_W  = FETCH_INSTR_W,
    parameter int                QDEPTH   = 4,
    parameter logic [ADDR_W-1:0] RESET_PC = '0,
    parameter int                PC_STEP  = 1
) (
    input logic                clk,
    input logic                rst_n,
    instr_fetch_unit_if.master bus
);

    localparam int PTR_W   = $clog2(QDEPTH);
    localparam int CNT_W   = PTR_W + 1;
    localparam int OCC_W   = CNT_W + 1;
    localparam int ENTRY_W = entry_width(ADDR_W, INSTR_W);

    logic               started;
    logic               inflight;
    logic               squash;
    logic [ADDR_W-1:0]  fetch_pc;
    logic [ADDR_W-1:0]  inflight_pc;

    logic               issue;
    logic               push;
    logic               pop;
    logic               flush;
    logic               q_full;
    logic               q_empty;
    logic [CNT_W-1:0]   q_count;
    logic [OCC_W-1:0]   occupancy;
    logic [ENTRY_W-1:0] head_entry;

    // Issue only when the queue can absorb this request plus the one already in flight.
    always_comb begin
        occupancy = {1'b0, q_count} + OCC_W'(inflight);
        issue     = started && !bus.redirect_valid && !q_full
                    && (occupancy < OCC_W'(QDEPTH));
        flush     = bus.redirect_valid;
        push      = inflight && !squash;
        pop       = !q_empty && bus.instr_ready && !bus.redirect_valid;
    end

    // PC, in-flight tracking and squash; a redirect overrides sequential fetch.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            started     <= 1'b0;
            inflight    <= 1'b0;
            squash      <= 1'b0;
            fetch_pc    <= RESET_PC;
            inflight_pc <= '0;
        end else begin
            started  <= 1'b1;
            inflight <= issue;
            squash   <= bus.redirect_valid;
            if (issue) begin
                inflight_pc <= fetch_pc;
            end
            if (bus.redirect_valid) begin
                fetch_pc <= bus.redirect_pc;
            end else if (issue) begin
                fetch_pc <= fetch_pc + ADDR_W'(PC_STEP);
            end
        end
    end

    fetch_queue #(
        .QDEPTH (QDEPTH),
        .WIDTH  (ENTRY_W)
    ) u_queue (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (push),
        .push_data ({inflight_pc, bus.imem_rdata}),
        .pop       (pop),
        .flush     (flush),
        .head_data (head_entry),
        .full      (q_full),
        .empty     (q_empty),
        .count     (q_count)
    );

    assign bus.imem_req    = issue;
    assign bus.imem_addr   = fetch_pc;
    assign bus.instr_valid = !q_empty;
    assign bus.instr       = head_entry[INSTR_W-1:0];
    assign bus.instr_pc    = head_entry[ENTRY_W-1:INSTR_W];

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Self-checking bench for instr_fetch_unit. Expected values come from the
// architectural rule "after reset or a redirect to T, decode receives T,
// T+1, T+2, ... with instr = mem[pc]", plus fixed latency expectations.
module tb_instr_fetch_unit;
    import fetch_pkg::*;

    localparam int QD = 4;

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    int tests_run  = 0;
    int fail_count = 0;

    logic [31:0] exp_pc;

    always #5 clk = ~clk;

    instr_fetch_unit_if #(.ADDR_W(32), .INSTR_W(32)) bus ();

    instr_fetch_unit #(
        .ADDR_W   (32),
        .INSTR_W  (32),
        .QDEPTH   (QD),
        .RESET_PC (32'h0),
        .PC_STEP  (1)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return 32'h1000 + a;
    endfunction

    // Synchronous instruction memory: data one cycle after the request.
    always @(posedge clk) begin
        if (bus.imem_req === 1'b1) begin
            bus.imem_rdata <= mem_word(bus.imem_addr);
        end
    end

    // Drive inputs on the falling edge, then settle before sampling.
    task automatic step(input logic rv, input logic [31:0] rpc, input logic rdy);
        @(negedge clk);
        bus.redirect_valid = rv;
        bus.redirect_pc    = rpc;
        bus.instr_ready    = rdy;
        #1;
    endtask

    task automatic hold_reset_then_release(input logic rdy);
        rst_n = 1'b0;
        bus.redirect_valid = 1'b0;
        bus.redirect_pc    = '0;
        bus.instr_ready    = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        bus.instr_ready = rdy;
        exp_pc = 32'h0;
    endtask

    task automatic test_reset();
        bus.redirect_valid = 1'b0;
        bus.redirect_pc    = '0;
        bus.instr_ready    = 1'b0;
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        tests_run++;
        if (bus.imem_req !== 1'b0) begin
            fail_count++; $display("[TB] FAIL reset_imem_req: got %b expected 0", bus.imem_req);
        end
        tests_run++;
        if (bus.imem_addr !== 32'h0) begin
            fail_count++; $display("[TB] FAIL reset_imem_addr: got %h expected 00000000", bus.imem_addr);
        end
        tests_run++;
        if (bus.instr_valid !== 1'b0) begin
            fail_count++; $display("[TB] FAIL reset_instr_valid: got %b expected 0", bus.instr_valid);
        end
        tests_run++;
        if (bus.instr !== 32'h0) begin
            fail_count++; $display("[TB] FAIL reset_instr: got %h expected 00000000", bus.instr);
        end
        tests_run++;
        if (bus.instr_pc !== 32'h0) begin
            fail_count++; $display("[TB] FAIL reset_instr_pc: got %h expected 00000000", bus.instr_pc);
        end
    endtask

    task automatic test_free_run();
        int first_req   = -1;
        int first_valid = -1;
        int gaps        = 0;
        int delivered   = 0;
        logic [31:0] exp_addr = 32'h0;
        @(negedge clk);
        rst_n = 1'b1;
        exp_pc = 32'h0;
        for (int k = 0; k < 20; k++) begin
            step(1'b0, 32'h0, 1'b1);
            if (bus.imem_req === 1'b1) begin
                if (first_req < 0) first_req = k;
                tests_run++;
                if (bus.imem_addr !== exp_addr) begin
                    fail_count++; $display("[TB] FAIL free_run_addr: got %h expected %h", bus.imem_addr, exp_addr);
                end
                exp_addr++;
            end
            if (bus.instr_valid === 1'b1) begin
                if (first_valid < 0) first_valid = k;
                tests_run++;
                if ({bus.instr_pc, bus.instr} !== {exp_pc, mem_word(exp_pc)}) begin
                    fail_count++;
                    $display("[TB] FAIL free_run_data: got pc=%h instr=%h expected pc=%h instr=%h",
                             bus.instr_pc, bus.instr, exp_pc, mem_word(exp_pc));
                end
                exp_pc++;
                delivered++;
            end else if (first_valid >= 0) begin
                gaps++;
            end
        end
        tests_run++;
        if (first_req != 0) begin
            fail_count++; $display("[TB] FAIL first_req_latency: got cycle %0d expected 0", first_req);
        end
        tests_run++;
        if (first_valid - first_req != 2) begin
            fail_count++; $display("[TB] FAIL req_to_valid: got %0d expected 2", first_valid - first_req);
        end
        tests_run++;
        if (gaps != 0 || delivered != 18) begin
            fail_count++; $display("[TB] FAIL throughput: got gaps=%0d delivered=%0d expected gaps=0 delivered=18", gaps, delivered);
        end
    endtask

    task automatic test_stall();
        int reqs = 0;
        int gaps = 0;
        logic [31:0] exp_addr;
        hold_reset_then_release(1'b0);
        for (int k = 0; k < 10; k++) begin
            step(1'b0, 32'h0, 1'b0);
            if (bus.imem_req === 1'b1) reqs++;
            if (k >= 2) begin
                tests_run++;
                if (bus.instr_valid !== 1'b1 || {bus.instr_pc, bus.instr} !== {32'h0, 32'h1000}) begin
                    fail_count++;
                    $display("[TB] FAIL stall_head_stable: got v=%b pc=%h instr=%h expected v=1 pc=00000000 instr=00001000",
                             bus.instr_valid, bus.instr_pc, bus.instr);
                end
            end
        end
        tests_run++;
        if (reqs != QD || bus.imem_req !== 1'b0) begin
            fail_count++; $display("[TB] FAIL stall_fill: got reqs=%0d req_now=%b expected reqs=%0d req_now=0", reqs, bus.imem_req, QD);
        end
        exp_addr = 32'(QD);
        for (int k = 0; k < 12; k++) begin
            step(1'b0, 32'h0, 1'b1);
            if (bus.imem_req === 1'b1) begin
                tests_run++;
                if (bus.imem_addr !== exp_addr) begin
                    fail_count++; $display("[TB] FAIL release_addr: got %h expected %h", bus.imem_addr, exp_addr);
                end
                exp_addr++;
            end
            if (bus.instr_valid === 1'b1) begin
                tests_run++;
                if ({bus.instr_pc, bus.instr} !== {exp_pc, mem_word(exp_pc)}) begin
                    fail_count++;
                    $display("[TB] FAIL release_data: got pc=%h instr=%h expected pc=%h instr=%h",
                             bus.instr_pc, bus.instr, exp_pc, mem_word(exp_pc));
                end
                exp_pc++;
            end else begin
                gaps++;
            end
        end
        tests_run++;
        if (gaps != 0 || exp_pc != 32'd12) begin
            fail_count++; $display("[TB] FAIL release_stream: got gaps=%0d next_pc=%h expected gaps=0 next_pc=0000000c", gaps, exp_pc);
        end
    endtask

    task automatic test_redirect();
        int first_valid = -1;
        hold_reset_then_release(1'b0);
        repeat (4) step(1'b0, 32'h0, 1'b0);
        step(1'b1, 32'h40, 1'b1);
        tests_run++;
        if (bus.instr_valid !== 1'b1 || bus.imem_req !== 1'b0) begin
            fail_count++; $display("[TB] FAIL redirect_cycle: got valid=%b req=%b expected valid=1 req=0", bus.instr_valid, bus.imem_req);
        end
        exp_pc = 32'h40;
        for (int k = 1; k <= 12; k++) begin
            step(1'b0, 32'h0, 1'b1);
            if (k == 1) begin
                tests_run++;
                if (bus.imem_req !== 1'b1 || bus.imem_addr !== 32'h40) begin
                    fail_count++; $display("[TB] FAIL redirect_first_req: got req=%b addr=%h expected req=1 addr=00000040", bus.imem_req, bus.imem_addr);
                end
            end
            if (bus.instr_valid === 1'b1) begin
                if (first_valid < 0) first_valid = k;
                tests_run++;
                if ({bus.instr_pc, bus.instr} !== {exp_pc, mem_word(exp_pc)}) begin
                    fail_count++;
                    $display("[TB] FAIL redirect_data: got pc=%h instr=%h expected pc=%h instr=%h",
                             bus.instr_pc, bus.instr, exp_pc, mem_word(exp_pc));
                end
                exp_pc++;
            end
        end
        tests_run++;
        if (first_valid != 3) begin
            fail_count++; $display("[TB] FAIL redirect_latency: got %0d expected 3", first_valid);
        end
    endtask

    task automatic test_back_to_back_redirect();
        int first_valid = -1;
        step(1'b1, 32'h80, 1'b1);
        tests_run++;
        if (bus.imem_req !== 1'b0) begin
            fail_count++; $display("[TB] FAIL b2b_req_first: got %b expected 0", bus.imem_req);
        end
        step(1'b1, 32'hC0, 1'b1);
        tests_run++;
        if (bus.imem_req !== 1'b0) begin
            fail_count++; $display("[TB] FAIL b2b_req_second: got %b expected 0", bus.imem_req);
        end
        exp_pc = 32'hC0;
        for (int k = 1; k <= 10; k++) begin
            step(1'b0, 32'h0, 1'b1);
            if (bus.instr_valid === 1'b1) begin
                if (first_valid < 0) first_valid = k;
                tests_run++;
                if ({bus.instr_pc, bus.instr} !== {exp_pc, mem_word(exp_pc)}) begin
                    fail_count++;
                    $display("[TB] FAIL b2b_data: got pc=%h instr=%h expected pc=%h instr=%h",
                             bus.instr_pc, bus.instr, exp_pc, mem_word(exp_pc));
                end
                exp_pc++;
            end
        end
        tests_run++;
        if (first_valid != 3) begin
            fail_count++; $display("[TB] FAIL b2b_latency: got %0d expected 3", first_valid);
        end
    endtask

    task automatic test_wrap();
        int delivered = 0;
        step(1'b1, 32'hFFFF_FFFF, 1'b1);
        exp_pc = 32'hFFFF_FFFF;
        for (int k = 1; k <= 8; k++) begin
            step(1'b0, 32'h0, 1'b1);
            if (bus.instr_valid === 1'b1) begin
                tests_run++;
                if ({bus.instr_pc, bus.instr} !== {exp_pc, mem_word(exp_pc)}) begin
                    fail_count++;
                    $display("[TB] FAIL wrap_data: got pc=%h instr=%h expected pc=%h instr=%h",
                             bus.instr_pc, bus.instr, exp_pc, mem_word(exp_pc));
                end
                exp_pc++;
                delivered++;
            end
        end
        tests_run++;
        if (delivered < 3) begin
            fail_count++; $display("[TB] FAIL wrap_count: got %0d expected at least 3", delivered);
        end
    endtask

    task automatic test_reset_mid();
        repeat (8) step(1'b0, 32'h0, 1'b0);
        tests_run++;
        if (bus.instr_valid !== 1'b1) begin
            fail_count++; $display("[TB] FAIL pre_reset_full: got valid=%b expected 1", bus.instr_valid);
        end
        #2;
        rst_n = 1'b0;
        #1;
        tests_run++;
        if ({bus.imem_req, bus.instr_valid} !== 2'b00) begin
            fail_count++; $display("[TB] FAIL async_reset_ctrl: got req=%b valid=%b expected 0 0", bus.imem_req, bus.instr_valid);
        end
        tests_run++;
        if ({bus.imem_addr, bus.instr, bus.instr_pc} !== 96'h0) begin
            fail_count++;
            $display("[TB] FAIL async_reset_data: got addr=%h instr=%h pc=%h expected all zero",
                     bus.imem_addr, bus.instr, bus.instr_pc);
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        bus.instr_ready = 1'b1;
        exp_pc = 32'h0;
        for (int k = 0; k < 8; k++) begin
            step(1'b0, 32'h0, 1'b1);
            if (k == 0) begin
                tests_run++;
                if (bus.imem_req !== 1'b1 || bus.imem_addr !== 32'h0) begin
                    fail_count++; $display("[TB] FAIL restart_req: got req=%b addr=%h expected req=1 addr=00000000", bus.imem_req, bus.imem_addr);
                end
            end
            if (bus.instr_valid === 1'b1) begin
                tests_run++;
                if ({bus.instr_pc, bus.instr} !== {exp_pc, mem_word(exp_pc)}) begin
                    fail_count++;
                    $display("[TB] FAIL restart_data: got pc=%h instr=%h expected pc=%h instr=%h",
                             bus.instr_pc, bus.instr, exp_pc, mem_word(exp_pc));
                end
                exp_pc++;
            end
        end
    endtask

    task automatic test_random();
        logic        rv;
        logic        rdy;
        logic [31:0] rpc;
        logic        prev_stall = 1'b0;
        logic [63:0] prev_pair  = '0;
        int          delivered  = 0;
        for (int k = 0; k < 1500; k++) begin
            rv  = ($urandom_range(0, 99) < 3);
            rdy = ($urandom_range(0, 99) < 70);
            rpc = $urandom;
            step(rv, rpc, rdy);
            if (prev_stall) begin
                tests_run++;
                if (bus.instr_valid !== 1'b1 || {bus.instr_pc, bus.instr} !== prev_pair) begin
                    fail_count++;
                    $display("[TB] FAIL rand_stable: got v=%b pair=%h expected v=1 pair=%h",
                             bus.instr_valid, {bus.instr_pc, bus.instr}, prev_pair);
                end
            end
            if (rv) begin
                tests_run++;
                if (bus.imem_req !== 1'b0) begin
                    fail_count++; $display("[TB] FAIL rand_redirect_req: got %b expected 0", bus.imem_req);
                end
            end else if (bus.instr_valid === 1'b1 && rdy) begin
                tests_run++;
                if ({bus.instr_pc, bus.instr} !== {exp_pc, mem_word(exp_pc)}) begin
                    fail_count++;
                    $display("[TB] FAIL rand_data: got pc=%h instr=%h expected pc=%h instr=%h",
                             bus.instr_pc, bus.instr, exp_pc, mem_word(exp_pc));
                end
                exp_pc++;
                delivered++;
            end
            if (rv) exp_pc = rpc;
            prev_stall = (bus.instr_valid === 1'b1) && !rdy && !rv;
            prev_pair  = {bus.instr_pc, bus.instr};
        end
        tests_run++;
        if (delivered < 300) begin
            fail_count++; $display("[TB] FAIL rand_progress: got %0d deliveries expected at least 300", delivered);
        end
    endtask

    initial begin
        test_reset();
        test_free_run();
        test_stall();
        test_redirect();
        test_back_to_back_redirect();
        test_wrap();
        test_reset_mid();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests_run, fail_count);
        $finish;
    end

endmodule
